sprite_update_scheduler: RTL
============================

# sprite_update_scheduler

Double-buffered position store for the on-screen sprites, placed between the CPU memory bus and the sprite renderers. The CPU writes X/Y coordinates into shadow registers at any time. A commit request arms the block. At the next start of vertical blanking, shadow values are copied to the active registers, one sprite per cycle, so the renderers never see a torn or half-updated frame.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprites (pacman plus ghosts); legal range 1..8
- COORD_W, 10, coordinate width, matching the horizontal/vertical counter width
- VBLANK_LINE, 480, first non-visible line number

Ports:
- clk  in  1  pixel clock (the divided clock used by the counters)
- rst  in  1  reset: asynchronous, active-low
- memWr  in  1  bus write strobe, active-low (0 = write)
- address  in  32  bus word address
- datoIn  in  32  bus write data
- datoOut  out  32  bus read data, combinational
- vcount  in  COORD_W  current line from the vertical counter
- sprite_x  out  NUM_SPRITES*COORD_W  active X positions; sprite i is at bits [i*COORD_W +: COORD_W]
- sprite_y  out  NUM_SPRITES*COORD_W  active Y positions, packed the same way as sprite_x
- frame_done  out  1  one-cycle pulse when a commit completes

## Operation
- Address map (word addresses):
  - 2i: shadow X of sprite i
  - 2i+1: shadow Y of sprite i
  - 0x10: CTRL
  - All other addresses are ignored on write and read as 0.
- Shadow write: on a clk edge with memWr=0 and a mapped address, the shadow register takes datoIn[COORD_W-1:0]. Upper bits are discarded. No range clamping.
- CTRL write with datoIn[0]=1 raises a commit request. A CTRL write with datoIn[0]=0 has no effect.
- CTRL read returns:
  - bit0: armed (state ARMED)
  - bit1: copying (state COPY)
  - bit2: pending (re-arm requested during COPY)
  - bits[31:16]: frame_cnt
  - all other bits: 0
- Shadow reads return the shadow value, zero-extended.
- vblank = (vcount >= VBLANK_LINE). vblank_d is a registered copy of vblank. vblank_start = vblank & ~vblank_d.
- frame_cnt (16 bits) increments on every vblank_start, in every state, and wraps from 0xFFFF to 0.
- FSM states:
  - IDLE: on a commit request, go to ARMED.
  - ARMED: a commit request changes nothing. On vblank_start, go to COPY with idx=0.
  - COPY: each cycle, active[idx] takes shadow[idx] and idx increments. After idx = NUM_SPRITES-1, pulse frame_done. Then go to ARMED if pending is set (clear pending), otherwise go to IDLE.
  - A commit request during COPY sets pending.
- Simultaneous shadow write and copy of the same index: the copy takes the pre-write shadow value.
- A write to a shadow index already copied in this COPY does not appear until the next commit. A write to a shadow index not yet copied is included in this commit.
- A commit request and vblank_start in the same cycle while IDLE: go to ARMED only. The copy waits for the next frame.

## Timing
- Reset values:
  - state IDLE, idx 0, pending 0, vblank_d 0, frame_cnt 0
  - all shadow and active registers 0
  - sprite_x = 0, sprite_y = 0, frame_done = 0
- Reset asserted mid-COPY aborts the copy immediately. All outputs return to their reset values.
- Shadow write latency: 1 cycle. A read in the cycle after the write edge returns the new value.
- Let cycle T have vblank_start=1 while in ARMED. Then:
  - Sprite i appears on the outputs after the edge ending cycle T+1+i.
  - frame_done is high during cycle T+NUM_SPRITES.
  - The state is IDLE/ARMED in cycle T+NUM_SPRITES+1.
- Total commit time is NUM_SPRITES cycles. This is always far shorter than vertical blanking.
- Outputs are registered. datoOut is combinational from address and registers only.

## Structure
- Package sprite_pkg holds:
  - the NUM_SPRITES, COORD_W, VBLANK_LINE and CTRL_ADDR (0x10) constants
  - the state enum (IDLE, ARMED, COPY)
  - the CTRL bit-position constants
- Sub-module vblank_detector contains vblank_d, vblank_start and frame_cnt. The FSM, register files and bus decode stay in the top level.

## Test plan
- Reset then release; idle for one frame: all sprite outputs 0, frame_done never pulses, and CTRL reads frame_cnt=1 after the first vblank_start.
- Write X0=100, Y0=200, then X1=0x3FF|0x400 (upper bit dropped), then commit at vcount=100: outputs unchanged until vcount reaches 480. Sprite 0 updates at T+1 to (100,200), sprite 1 updates at T+2 to X=0x3FF, and frame_done pulses at T+4.
- Shadow write to sprite 3 during COPY cycle idx=1 with value 55: the new value 55 is committed. A write to sprite 0 in the same cycle is not committed until the next commit.
- Commit request during COPY: pending=1 reads back in CTRL, state ends in ARMED, and the second copy happens at the next frame's vblank_start.
- Commit request coinciding with vblank_start while IDLE: no copy this frame; the copy occurs exactly one frame later.
- Assert rst at COPY idx=2: all outputs are 0 immediately, state is IDLE after release, and there is no frame_done pulse.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite position double-buffer.
package sprite_pkg;

  localparam int NUM_SPRITES = 4;
  localparam int COORD_W     = 10;
  localparam int VBLANK_LINE = 480;
  localparam int FRAME_CNT_W = 16;

  localparam logic [31:0] CTRL_ADDR = 32'h0000_0010;

  // CTRL write bit
  localparam int CTRL_COMMIT_BIT  = 0;
  // CTRL read bits
  localparam int CTRL_ARMED_BIT   = 0;
  localparam int CTRL_COPYING_BIT = 1;
  localparam int CTRL_PENDING_BIT = 2;
  localparam int CTRL_FCNT_LSB    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } state_t;

endpackage

// File: rtl/vblank_detector.sv
// Detects the first cycle of vertical blanking and counts frames.
module vblank_detector #(
  parameter int COORD_W     = 10,
  parameter int VBLANK_LINE = 480,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] vcount,
  output logic               vblank_start,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam logic [COORD_W-1:0] VBLANK_VAL = COORD_W'(VBLANK_LINE);

  logic             vblank;
  logic             vblank_d_reg;
  logic [CNT_W-1:0] frame_cnt_reg;

  assign vblank       = (vcount >= VBLANK_VAL);
  assign vblank_start = vblank & ~vblank_d_reg;
  assign frame_cnt    = frame_cnt_reg;

  // Delayed copy of vblank for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblank_d_reg <= 1'b0;
    end else begin
      vblank_d_reg <= vblank;
    end
  end

  // Free-running frame counter, wraps naturally at full scale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_reg <= '0;
    end else if (vblank_start) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_update_scheduler.sv
// Double-buffered sprite position store: the CPU fills shadow registers,
// and a commit copies them to the active registers at the start of vblank,
// one sprite per cycle, so renderers never see a half-updated frame.
module sprite_update_scheduler #(
  parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
  parameter int COORD_W     = sprite_pkg::COORD_W,
  parameter int VBLANK_LINE = sprite_pkg::VBLANK_LINE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           memWr,
  input  logic [31:0]                    address,
  input  logic [31:0]                    datoIn,
  output logic [31:0]                    datoOut,
  input  logic [COORD_W-1:0]             vcount,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  output logic                           frame_done
);

  import sprite_pkg::state_t;
  import sprite_pkg::IDLE;
  import sprite_pkg::ARMED;
  import sprite_pkg::COPY;
  import sprite_pkg::CTRL_ADDR;
  import sprite_pkg::CTRL_COMMIT_BIT;
  import sprite_pkg::CTRL_ARMED_BIT;
  import sprite_pkg::CTRL_COPYING_BIT;
  import sprite_pkg::CTRL_PENDING_BIT;
  import sprite_pkg::CTRL_FCNT_LSB;
  import sprite_pkg::FRAME_CNT_W;

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SPRITES - 1);
  // Index during which frame_done must be scheduled so it is high in the last copy cycle
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'((NUM_SPRITES > 1) ? NUM_SPRITES - 2 : 0);
  localparam logic [31:0]      SHADOW_END = 32'(2 * NUM_SPRITES);

  logic [COORD_W-1:0] shadow_x [NUM_SPRITES];
  logic [COORD_W-1:0] shadow_y [NUM_SPRITES];
  logic [COORD_W-1:0] active_x [NUM_SPRITES];
  logic [COORD_W-1:0] active_y [NUM_SPRITES];

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             pending_reg;
  logic             frame_done_reg;

  logic                   vblank_start;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  logic             wr_en;
  logic             shadow_hit;
  logic             ctrl_hit;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_y;
  logic             commit_req;
  logic             unused_data;

  // Bus decode: even word = X, odd word = Y, sprite index in the bits above
  assign wr_en       = ~memWr;
  assign shadow_hit  = (address < SHADOW_END);
  assign ctrl_hit    = (address == CTRL_ADDR);
  assign sel_idx     = address[IDX_W:1];
  assign sel_y       = address[0];
  assign commit_req  = wr_en & ctrl_hit & datoIn[CTRL_COMMIT_BIT];
  assign unused_data = ^datoIn[31:COORD_W];

  vblank_detector #(
    .COORD_W     (COORD_W),
    .VBLANK_LINE (VBLANK_LINE),
    .CNT_W       (FRAME_CNT_W)
  ) u_vblank (
    .clk          (clk),
    .rst          (rst),
    .vcount       (vcount),
    .vblank_start (vblank_start),
    .frame_cnt    (frame_cnt)
  );

  // CPU writes into the shadow bank; upper data bits are simply dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
    end else if (wr_en && shadow_hit) begin
      if (sel_y) begin
        shadow_y[sel_idx] <= datoIn[COORD_W-1:0];
      end else begin
        shadow_x[sel_idx] <= datoIn[COORD_W-1:0];
      end
    end
  end

  // Commit FSM: arm on request, copy one sprite per cycle from vblank start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        active_x[i] <= '0;
        active_y[i] <= '0;
      end
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // vblank_start is deliberately ignored here: the copy waits a frame
          if (commit_req) begin
            state_reg <= ARMED;
          end
        end
        ARMED: begin
          if (vblank_start) begin
            state_reg      <= COPY;
            idx_reg        <= '0;
            frame_done_reg <= (NUM_SPRITES == 1);
          end
        end
        COPY: begin
          // Reads the shadow value from before any same-edge CPU write
          active_x[idx_reg] <= shadow_x[idx_reg];
          active_y[idx_reg] <= shadow_y[idx_reg];
          if (idx_reg == LAST_IDX) begin
            idx_reg     <= '0;
            pending_reg <= 1'b0;
            state_reg   <= (pending_reg || commit_req) ? ARMED : IDLE;
          end else begin
            idx_reg        <= idx_reg + 1'b1;
            frame_done_reg <= (idx_reg == PENULT_IDX);
            if (commit_req) begin
              pending_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Flatten the active bank onto the packed renderer buses
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_pack
    assign sprite_x[gi*COORD_W +: COORD_W] = active_x[gi];
    assign sprite_y[gi*COORD_W +: COORD_W] = active_y[gi];
  end

  assign frame_done = frame_done_reg;

  // Read mux: shadow values zero-extended, CTRL status, zero elsewhere
  always_comb begin
    datoOut = '0;
    if (shadow_hit) begin
      datoOut[COORD_W-1:0] = sel_y ? shadow_y[sel_idx] : shadow_x[sel_idx];
    end else if (ctrl_hit) begin
      datoOut[CTRL_ARMED_BIT]                    = (state_reg == ARMED);
      datoOut[CTRL_COPYING_BIT]                  = (state_reg == COPY);
      datoOut[CTRL_PENDING_BIT]                  = pending_reg;
      datoOut[CTRL_FCNT_LSB +: FRAME_CNT_W]      = frame_cnt;
    end
  end

endmodule
